// File: rtl/axi_pkg.sv
// axi_pkg: shared encodings for the AXI SRAM responder.
//   - burst encodings (FIXED/INCR/WRAP)
//   - response encodings (OKAY/SLVERR/DECERR)
//   - responder FSM state enum
//   - per-beat helpers: response classification, worst-of merge, address step
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD      = 2'd1,
    WR_DATA = 2'd2,
    WR_RESP = 2'd3
  } state_t;

  // Unsupported burst type or beat size outranks an address decode miss.
  function automatic logic [1:0] beat_resp(input logic [1:0] burst,
                                           input logic [2:0] size,
                                           input logic       in_range);
    if (!(burst == BURST_FIXED || burst == BURST_INCR) || size > 3'd2)
      return RESP_SLVERR;
    if (!in_range)
      return RESP_DECERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [1:0] resp_worst(input logic [1:0] a,
                                            input logic [1:0] b);
    if (a == RESP_DECERR || b == RESP_DECERR) return RESP_DECERR;
    if (a == RESP_SLVERR || b == RESP_SLVERR) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  // Only INCR moves; FIXED and the error bursts keep the start address.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [1:0]  burst,
                                            input logic [2:0]  size);
    if (burst == BURST_INCR) return addr + (32'd1 << size);
    return addr;
  endfunction

endpackage

// File: rtl/sram_1p.sv
// sram_1p: single-port 32-bit word storage.
//   clk   - clock, rising edge
//   en    - port enable; a read happens when en is high and we is all zero
//   we    - per-byte write enables
//   addr  - word index
//   wdata - write data
//   rdata - registered read data, valid the cycle after a read, held otherwise
// Storage has no reset.
module sram_1p #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      if (we == 4'b0000) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/axi_sram_responder.sv
// axi_sram_responder: AXI3 slave backed by a single-port SRAM, one
// transaction in flight at a time.
//   aclk, areset        - clock, synchronous active-high reset
//   ar* / r*            - read address and read data channels
//   aw* / w* / b*       - write address, write data and write response channels
//   BASE_ADDR           - byte base of the RAM window
//   DEPTH_LOG2          - log2 of the number of 32-bit words
//
// state   | meaning
// IDLE    | arbitrate AR/AW, raise the granted ready, wait for its handshake
// RD      | stream read beats through a two-stage (sram, output) pipeline
// WR_DATA | accept W beats and write them straight into the SRAM
// WR_RESP | hold bvalid until bready
module axi_sram_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          DEPTH_LOG2 = 12
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  import axi_pkg::*;

  state_t      state;
  logic        wr_pri;

  logic [3:0]  t_id;
  logic [31:0] t_addr;
  logic [7:0]  t_len;
  logic [2:0]  t_size;
  logic [1:0]  t_burst;

  logic [8:0]  rd_left;
  logic        s1_valid;
  logic [1:0]  s1_resp;
  logic        s1_last;

  logic [8:0]  w_cnt;
  logic [1:0]  w_resp;

  logic        in_range;
  logic [1:0]  cur_resp;
  logic [31:0] addr_next;
  logic        s1_adv;
  logic        rd_issue;
  logic        w_hs;
  logic        w_in_len;
  logic [1:0]  w_resp_upd;
  logic [3:0]  mem_we;
  logic        mem_en;
  logic [31:0] mem_rdata;

  logic        unused_ok;
  assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

  assign in_range  = (t_addr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]);
  assign cur_resp  = beat_resp(t_burst, t_size, in_range);
  assign addr_next = next_addr(t_addr, t_burst, t_size);

  // Stage 1 is the SRAM output register; it drains into the R output
  // register whenever that is empty or being accepted. A new read is issued
  // only when stage 1 is free at the next edge, so no beat is overwritten.
  assign s1_adv   = s1_valid && (!rvalid || rready);
  assign rd_issue = (state == RD) && (rd_left != 9'd0) && (!s1_valid || s1_adv);

  // Beats past awlen+1 and errored beats never reach the RAM.
  assign w_hs       = (state == WR_DATA) && wready && wvalid;
  assign w_in_len   = (w_cnt <= {1'b0, t_len});
  assign w_resp_upd = w_in_len ? resp_worst(w_resp, cur_resp) : w_resp;
  assign mem_we     = (w_hs && w_in_len && cur_resp == RESP_OKAY) ? wstrb : 4'b0000;
  assign mem_en     = rd_issue || (mem_we != 4'b0000);

  sram_1p #(.DEPTH_LOG2(DEPTH_LOG2)) u_sram (
    .clk   (aclk),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (t_addr[DEPTH_LOG2+1:2]),
    .wdata (wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state    <= IDLE;
      wr_pri   <= 1'b1;
      arready  <= 1'b0;
      awready  <= 1'b0;
      wready   <= 1'b0;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      rid      <= '0;
      rdata    <= '0;
      rresp    <= '0;
      bvalid   <= 1'b0;
      bid      <= '0;
      bresp    <= '0;
      t_id     <= '0;
      t_addr   <= '0;
      t_len    <= '0;
      t_size   <= '0;
      t_burst  <= '0;
      rd_left  <= '0;
      s1_valid <= 1'b0;
      s1_resp  <= '0;
      s1_last  <= 1'b0;
      w_cnt    <= '0;
      w_resp   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (awready && awvalid) begin
            awready <= 1'b0;
            wready  <= 1'b1;
            t_id    <= awid;
            t_addr  <= awaddr;
            t_len   <= awlen;
            t_size  <= awsize;
            t_burst <= awburst;
            w_cnt   <= '0;
            w_resp  <= RESP_OKAY;
            state   <= WR_DATA;
          end else if (arready && arvalid) begin
            arready  <= 1'b0;
            rid      <= arid;
            t_id     <= arid;
            t_addr   <= araddr;
            t_len    <= arlen;
            t_size   <= arsize;
            t_burst  <= arburst;
            rd_left  <= {1'b0, arlen} + 9'd1;
            s1_valid <= 1'b0;
            state    <= RD;
          end else if (!arready && !awready) begin
            // Priority only flips when both channels actually contend.
            if (awvalid && arvalid) begin
              if (wr_pri) awready <= 1'b1;
              else        arready <= 1'b1;
              wr_pri <= !wr_pri;
            end else if (awvalid) begin
              awready <= 1'b1;
            end else if (arvalid) begin
              arready <= 1'b1;
            end
          end
        end

        RD: begin
          if (rd_issue) begin
            rd_left  <= rd_left - 9'd1;
            t_addr   <= addr_next;
            s1_valid <= 1'b1;
            s1_resp  <= cur_resp;
            s1_last  <= (rd_left == 9'd1);
          end else if (s1_adv) begin
            s1_valid <= 1'b0;
          end

          if (s1_adv) begin
            rvalid <= 1'b1;
            rdata  <= (s1_resp == RESP_OKAY) ? mem_rdata : 32'h0;
            rresp  <= s1_resp;
            rlast  <= s1_last;
          end else if (rvalid && rready) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            if (rlast) state <= IDLE;
          end
        end

        WR_DATA: begin
          if (w_hs) begin
            if (w_in_len) t_addr <= addr_next;
            if (w_cnt != 9'h1FF) w_cnt <= w_cnt + 9'd1;
            w_resp <= w_resp_upd;
            if (wlast) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bid    <= t_id;
              // This beat is number w_cnt+1; anything but awlen+1 is a protocol error.
              bresp  <= resp_worst(w_resp_upd,
                                   (w_cnt == {1'b0, t_len}) ? RESP_OKAY : RESP_SLVERR);
              state  <= WR_RESP;
            end
          end
        end

        WR_RESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_responder.sv
`timescale 1ns/1ps
module tb_axi_sram_responder;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          DL2  = 12;

  logic        aclk = 1'b0;
  logic        areset;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock = 2'b00;
  logic [3:0]  arcache = 4'h0;
  logic [2:0]  arprot = 3'h0;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock = 2'b01;
  logic [3:0]  awcache = 4'h3;
  logic [2:0]  awprot = 3'h2;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid = 4'h9;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  always #5 aclk = ~aclk;

  axi_sram_responder #(.BASE_ADDR(BASE), .DEPTH_LOG2(DL2)) dut (
    .aclk(aclk), .areset(areset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int errors = 0;

  // Reference memory: word index -> contents, unknown bytes are X.
  logic [31:0] ref_mem [int];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i,
                                            input logic [2:0] size, input logic [1:0] burst);
    if (burst == 2'b01) return a + 32'(i) * (32'd1 << size);
    return a;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a, input logic [2:0] size,
                                          input logic [1:0] burst);
    if (burst > 2'b01 || size > 3'd2) return 2'b10;
    if ((a >> (DL2 + 2)) != (BASE >> (DL2 + 2))) return 2'b11;
    return 2'b00;
  endfunction

  function automatic int rank(input logic [1:0] r);
    return (r == 2'b11) ? 2 : ((r == 2'b10) ? 1 : 0);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[DL2+1:2]);
  endfunction

  // Apply n W beats (wd/ws) to a burst; returns the expected bresp.
  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst,
                                             input int n);
    logic [1:0]  worst;
    logic [1:0]  r;
    logic [31:0] a;
    logic [31:0] w;
    int          lim;
    worst = 2'b00;
    lim = (n < int'(len) + 1) ? n : int'(len) + 1;
    for (int i = 0; i < lim; i++) begin
      a = beat_addr(addr, i, size, burst);
      r = exp_resp(a, size, burst);
      if (rank(r) > rank(worst)) worst = r;
      if (r == 2'b00) begin
        w = ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : 32'hxxxx_xxxx;
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) w[8*b +: 8] = wd[i][8*b +: 8];
        ref_mem[widx(a)] = w;
      end
    end
    if (n != int'(len) + 1 && rank(worst) < 1) worst = 2'b10;
    return worst;
  endfunction

  task automatic do_reset();
    areset = 1'b1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
    rready = 1'b0; bready = 1'b0;
    tick();
    tick();
    areset = 1'b0;
  endtask

  task automatic issue_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int g;
    g = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    while (!awready && g < 50) begin tick(); g++; end
    checks++;
    if (awready !== 1'b1) begin
      errors++;
      $display("FAIL aw_handshake: awready=%b after %0d cycles, required 1", awready, g);
    end
    tick();
    awvalid = 1'b0;
  endtask

  task automatic issue_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int g;
    g = 0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    while (!arready && g < 50) begin tick(); g++; end
    checks++;
    if (arready !== 1'b1) begin
      errors++;
      $display("FAIL ar_handshake: arready=%b after %0d cycles, required 1", arready, g);
    end
    tick();
    arvalid = 1'b0;
  endtask

  task automatic send_w(input int n);
    for (int i = 0; i < n; i++) begin
      int g;
      g = 0;
      wdata = wd[i]; wstrb = ws[i]; wlast = (i == n - 1); wvalid = 1'b1;
      while (!wready && g < 50) begin tick(); g++; end
      checks++;
      if (wready !== 1'b1) begin
        errors++;
        $display("FAIL w_handshake: beat %0d wready=%b, required 1", i, wready);
      end
      tick();
    end
    wvalid = 1'b0;
    wlast = 1'b0;
  endtask

  task automatic get_b(input logic [3:0] exp_id, input logic [1:0] exp_bresp);
    int g;
    g = 0;
    bready = 1'b1;
    while (!bvalid && g < 50) begin tick(); g++; end
    checks++;
    if (bvalid !== 1'b1) begin
      errors++;
      $display("FAIL b_timeout: bvalid=%b, required 1", bvalid);
    end
    checks++;
    if (bid !== exp_id) begin
      errors++;
      $display("FAIL bid: got %h required %h", bid, exp_id);
    end
    checks++;
    if (bresp !== exp_bresp) begin
      errors++;
      $display("FAIL bresp: got %b required %b", bresp, exp_bresp);
    end
    tick();
    bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0) begin
      errors++;
      $display("FAIL b_drop: bvalid=%b after handshake, required 0", bvalid);
    end
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int n);
    logic [1:0] eb;
    issue_aw(id, addr, len, size, burst);
    send_w(n);
    eb = model_write(addr, len, size, burst, n);
    get_b(id, eb);
  endtask

  // Called at the sample point just after the AR handshake edge.
  // mode: 0 rready held high, 1 toggling 1/0, 2 random. stop_beat >= 0 returns
  // while that beat is on the bus.
  task automatic collect_r(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode,
                           input int stop_beat);
    int          lat, k, g;
    logic [31:0] a, ed;
    logic [1:0]  er;
    lat = 0; k = 0; g = 0;
    rready = 1'b0;
    while (!rvalid && lat < 20) begin tick(); lat++; end
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL r_latency: first rvalid after %0d cycles, required 2", lat);
    end
    while (k <= int'(len) && g < 3000) begin
      case (mode)
        0:       rready = 1'b1;
        1:       rready = (g % 2 == 0);
        default: rready = 1'($urandom_range(0, 1));
      endcase
      if (rvalid) begin
        a  = beat_addr(addr, k, size, burst);
        er = exp_resp(a, size, burst);
        ed = (er != 2'b00) ? 32'h0 :
             (ref_mem.exists(widx(a)) ? ref_mem[widx(a)] : 32'hxxxx_xxxx);
        checks++;
        if (rid !== id) begin
          errors++;
          $display("FAIL rid: beat %0d got %h required %h", k, rid, id);
        end
        checks++;
        if (rresp !== er) begin
          errors++;
          $display("FAIL rresp: beat %0d got %b required %b", k, rresp, er);
        end
        checks++;
        if (rlast !== (k == int'(len))) begin
          errors++;
          $display("FAIL rlast: beat %0d got %b required %b", k, rlast, (k == int'(len)));
        end
        if (!$isunknown(ed)) begin
          checks++;
          if (rdata !== ed) begin
            errors++;
            $display("FAIL rdata: beat %0d addr %h got %h required %h", k, a, rdata, ed);
          end
        end
        if (k == stop_beat) return;
        if (rready) k++;
      end
      tick();
      g++;
    end
    rready = 1'b0;
    checks++;
    if (k <= int'(len)) begin
      errors++;
      $display("FAIL r_timeout: %0d of %0d beats received", k, int'(len) + 1);
    end
    checks++;
    if (rvalid !== 1'b0) begin
      errors++;
      $display("FAIL r_after_last: rvalid=%b, required 0", rvalid);
    end
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int mode);
    issue_ar(id, addr, len, size, burst);
    collect_r(id, addr, len, size, burst, mode, -1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({arready, awready, wready, rvalid, bvalid, rlast} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ar/aw/w ready, rvalid, bvalid, rlast = %b, required 000000",
               {arready, awready, wready, rvalid, bvalid, rlast});
    end
    checks++;
    if ({rid, bid, rresp, bresp, rdata} !== 44'h0) begin
      errors++;
      $display("FAIL reset_data: rid %h bid %h rresp %b bresp %b rdata %h, required all 0",
               rid, bid, rresp, bresp, rdata);
    end
    tick();
    checks++;
    if ({arready, awready, wready} !== 3'b0) begin
      errors++;
      $display("FAIL idle_ready: ar/aw/w ready = %b with no requests, required 000",
               {arready, awready, wready});
    end
  endtask

  task automatic test_single();
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    write_burst(4'h1, 32'h100, 8'd0, 3'd2, 2'b01, 1);
    read_burst(4'h2, 32'h100, 8'd0, 3'd2, 2'b01, 0);
  endtask

  task automatic test_incr_stall();
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    write_burst(4'h3, 32'h200, 8'd3, 3'd2, 2'b01, 4);
    read_burst(4'h4, 32'h200, 8'd3, 3'd2, 2'b01, 1);
  endtask

  task automatic test_strobe();
    wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
    write_burst(4'h5, 32'h300, 8'd0, 3'd2, 2'b01, 1);
    wd[0] = 32'h00000000; ws[0] = 4'b0101;
    write_burst(4'h5, 32'h300, 8'd0, 3'd2, 2'b01, 1);
    read_burst(4'h6, 32'h300, 8'd0, 3'd2, 2'b01, 0);
  endtask

  task automatic test_errors();
    read_burst(4'h7, BASE + (32'd4 << DL2), 8'd1, 3'd2, 2'b01, 0);
    read_burst(4'h8, 32'h100, 8'd0, 3'd2, 2'b10, 0);
    read_burst(4'h9, 32'h100, 8'd1, 3'd3, 2'b01, 0);
    wd[0] = 32'h12345678; ws[0] = 4'hF;
    write_burst(4'hA, BASE + (32'd4 << DL2), 8'd0, 3'd2, 2'b01, 1);
    write_burst(4'hB, 32'h100, 8'd0, 3'd2, 2'b11, 1);
    read_burst(4'hC, 32'h100, 8'd0, 3'd2, 2'b01, 0);
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0A0_0000 + 32'(i); ws[i] = 4'hF; end
    write_burst(4'hD, 32'h500, 8'd3, 3'd2, 2'b01, 4);
    for (int i = 0; i < 4; i++) wd[i] = 32'h5B5B_0000 + 32'(i);
    write_burst(4'hD, 32'h500, 8'd3, 3'd2, 2'b01, 2);
    for (int i = 0; i < 4; i++) wd[i] = 32'hC3C3_0000 + 32'(i);
    write_burst(4'hE, 32'h500, 8'd1, 3'd2, 2'b01, 4);
    read_burst(4'hF, 32'h500, 8'd3, 3'd2, 2'b01, 0);
  endtask

  task automatic test_arbitration();
    int g;
    do_reset();
    awid = 4'h1; awaddr = 32'h600; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01;
    arid = 4'h2; araddr = 32'h600; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
    awvalid = 1'b1; arvalid = 1'b1;
    g = 0;
    while (!awready && !arready && g < 20) begin tick(); g++; end
    checks++;
    if ({awready, arready} !== 2'b10) begin
      errors++;
      $display("FAIL arb_first: awready/arready = %b, required 10", {awready, arready});
    end
    tick();
    awvalid = 1'b0;
    wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
    send_w(1);
    get_b(4'h1, model_write(32'h600, 8'd0, 3'd2, 2'b01, 1));
    issue_ar(4'h2, 32'h600, 8'd0, 3'd2, 2'b01);
    collect_r(4'h2, 32'h600, 8'd0, 3'd2, 2'b01, 0, -1);

    awid = 4'h3; awaddr = 32'h604; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01;
    arid = 4'h4; araddr = 32'h600; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
    awvalid = 1'b1; arvalid = 1'b1;
    g = 0;
    while (!awready && !arready && g < 20) begin tick(); g++; end
    checks++;
    if ({awready, arready} !== 2'b01) begin
      errors++;
      $display("FAIL arb_second: awready/arready = %b, required 01", {awready, arready});
    end
    tick();
    arvalid = 1'b0;
    collect_r(4'h4, 32'h600, 8'd0, 3'd2, 2'b01, 0, -1);
    issue_aw(4'h3, 32'h604, 8'd0, 3'd2, 2'b01);
    wd[0] = 32'h0BADCAFE; ws[0] = 4'hF;
    send_w(1);
    get_b(4'h3, model_write(32'h604, 8'd0, 3'd2, 2'b01, 1));
  endtask

  task automatic test_init_region();
    for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    write_burst(4'h8, 32'h1000, 8'd255, 3'd2, 2'b01, 256);
  endtask

  task automatic test_reset_midburst();
    issue_ar(4'h6, 32'h1000, 8'd7, 3'd2, 2'b01);
    collect_r(4'h6, 32'h1000, 8'd7, 3'd2, 2'b01, 0, 2);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    rready = 1'b0;
    checks++;
    if ({rvalid, rlast, arready, awready, wready, bvalid} !== 6'b0) begin
      errors++;
      $display("FAIL midburst_reset: rvalid/rlast/arready/awready/wready/bvalid = %b, required 000000",
               {rvalid, rlast, arready, awready, wready, bvalid});
    end
    checks++;
    if ({rid, rresp, rdata} !== 38'h0) begin
      errors++;
      $display("FAIL midburst_reset_data: rid %h rresp %b rdata %h, required 0", rid, rresp, rdata);
    end
    tick();
    checks++;
    if (rvalid !== 1'b0) begin
      errors++;
      $display("FAIL midburst_idle: rvalid=%b, required 0", rvalid);
    end
    read_burst(4'h7, 32'h1004, 8'd2, 3'd2, 2'b01, 0);
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          n;
    for (int it = 0; it < 30; it++) begin
      addr  = 32'h1000 + 32'(4 * $urandom_range(0, 200));
      len   = 8'($urandom_range(0, 7));
      size  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 3)) : 3'd2;
      burst = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        n = int'(len) + 1;
        if ($urandom_range(0, 3) == 0) n = int'(len) + 1 + int'($urandom_range(0, 2)) - 1;
        if (n < 1) n = 1;
        for (int i = 0; i < n; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
        write_burst(4'($urandom_range(0, 15)), addr, len, size, burst, n);
      end else begin
        read_burst(4'($urandom_range(0, 15)), addr, len, size, burst, 2);
      end
    end
  endtask

  initial begin
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    rready = 1'b0; bready = 1'b0; areset = 1'b1;
    test_reset();
    test_single();
    test_incr_stall();
    test_strobe();
    test_errors();
    test_arbitration();
    test_init_region();
    test_reset_midburst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete within 600000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
